// File: rtl/alarm_pkg.sv
// alarm_pkg: state encoding and BCD hh:mm <-> minute-of-day helpers shared by alarm_ctrl.
package alarm_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;
  localparam logic [1:0] ST_CHIME  = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StRing   = ST_RING,
    StSnooze = ST_SNOOZE,
    StChime  = ST_CHIME
  } state_e;

  localparam int unsigned MIN_PER_DAY = 1440;

  // BCD hh:mm to minute of day, 0..1439 for valid input.
  function automatic logic [10:0] bcd_hm_to_min(input logic [15:0] hm);
    return 11'(hm[15:12]) * 11'd600 + 11'(hm[11:8]) * 11'd60
         + 11'(hm[7:4]) * 11'd10 + 11'(hm[3:0]);
  endfunction

  // Minute of day (0..1439) back to BCD hh:mm.
  function automatic logic [15:0] min_to_bcd_hm(input logic [10:0] mins);
    logic [10:0] h;
    logic [10:0] m;
    h = mins / 11'd60;
    m = mins % 11'd60;
    return {4'(h / 11'd10), 4'(h % 11'd10), 4'(m / 11'd10), 4'(m % 11'd10)};
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: time/key inputs and melody/status outputs of the alarm controller.
// music_done exists only when HOURLY_CHIME_EN is defined.
interface alarm_ctrl_if;
  logic        alarm_on;
  logic [15:0] alarm_hm;
  logic [23:0] time_num;
  logic        key_stop;
  logic        key_snooze;
`ifdef HOURLY_CHIME_EN
  logic        music_done;
`endif
  logic        play_en;
  logic        ringing;
  logic        snooze_active;
  logic [1:0]  snooze_cnt;

  modport master (
`ifdef HOURLY_CHIME_EN
    output music_done,
`endif
    output alarm_on, alarm_hm, time_num, key_stop, key_snooze,
    input  play_en, ringing, snooze_active, snooze_cnt
  );

  modport slave (
`ifdef HOURLY_CHIME_EN
    input  music_done,
`endif
    input  alarm_on, alarm_hm, time_num, key_stop, key_snooze,
    output play_en, ringing, snooze_active, snooze_cnt
  );
endinterface

// File: rtl/alarm_tick_gen.sv
// alarm_tick_gen: free-running prescaler, sec_tick pulses one cycle each time the count wraps.
module alarm_tick_gen #(
  parameter int unsigned CLK_FREQ = 48000000
) (
  input  logic clk,
  input  logic rst,
  output logic sec_tick
);

  localparam int unsigned CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

  logic [CW-1:0] cnt_q;

  // Count 0..CLK_FREQ-1; tick is high for the cycle in which the count is back at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      sec_tick <= 1'b0;
    end else begin
      cnt_q    <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      sec_tick <= (cnt_q == LAST);
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm match, ring/snooze/stop sequencing and melody enable.
// Define HOURLY_CHIME_EN to add the hourly CHIME state and the music_done input.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 48000000,
  parameter int unsigned SNOOZE_MIN     = 5,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input logic         clk,
  input logic         rst,
  alarm_ctrl_if.slave bus
);

  logic        sec_tick;
  state_e      state_q;
  logic        match_q, snz_match_q, alarm_on_q;
  logic [15:0] snz_hm_q;
  logic [7:0]  ring_timer_q;
  logic [1:0]  snooze_cnt_q;
  logic        play_en_q, snooze_active_q;

  logic        alarm_match, alarm_hit, snz_match, snz_hit, alarm_fall;
  logic [10:0] snz_min;
  logic [15:0] snz_target;

  alarm_tick_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .sec_tick(sec_tick)
  );

  // Edge-detected alarm/snooze matches and the wrapped snooze target time.
  always_comb begin
    alarm_match = bus.alarm_on && (bus.time_num == {bus.alarm_hm, 8'h00});
    alarm_hit   = alarm_match && !match_q;
    snz_match   = bus.alarm_on && (bus.time_num == {snz_hm_q, 8'h00});
    snz_hit     = snz_match && !snz_match_q;
    alarm_fall  = alarm_on_q && !bus.alarm_on;
    // SNOOZE_MIN <= 59 so one conditional subtract is enough to wrap past midnight.
    snz_min     = bcd_hm_to_min(bus.time_num[23:8]) + 11'(SNOOZE_MIN);
    if (snz_min >= 11'(MIN_PER_DAY)) snz_min = snz_min - 11'(MIN_PER_DAY);
    snz_target  = min_to_bcd_hm(snz_min);
  end

`ifdef HOURLY_CHIME_EN
  logic hour_q, hour_match, hour_hit;

  // Hour boundary detect for the chime, independent of the alarm switch.
  always_comb begin
    hour_match = (bus.time_num[15:0] == 16'h0000);
    hour_hit   = hour_match && !hour_q;
  end
`endif

  // Sequencer state, edge-detect history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      match_q         <= 1'b0;
      snz_match_q     <= 1'b0;
      alarm_on_q      <= 1'b0;
      snz_hm_q        <= '0;
      ring_timer_q    <= '0;
      snooze_cnt_q    <= '0;
      play_en_q       <= 1'b0;
      snooze_active_q <= 1'b0;
`ifdef HOURLY_CHIME_EN
      hour_q          <= 1'b0;
`endif
    end else begin
      match_q         <= alarm_match;
      snz_match_q     <= snz_match;
      alarm_on_q      <= bus.alarm_on;
      play_en_q       <= (state_q == StRing) || (state_q == StChime);
      snooze_active_q <= (state_q == StSnooze);
`ifdef HOURLY_CHIME_EN
      hour_q          <= hour_match;
`endif
      if (alarm_fall) begin
        state_q      <= StIdle;
        snooze_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (alarm_hit) begin
              state_q      <= StRing;
              snooze_cnt_q <= '0;
              ring_timer_q <= '0;
            end
`ifdef HOURLY_CHIME_EN
            else if (hour_hit) state_q <= StChime;
`endif
          end
          StRing: begin
            // Keys outrank the timeout; stop outranks snooze.
            if (bus.key_stop) begin
              state_q <= StIdle;
            end else if (bus.key_snooze) begin
              if (snooze_cnt_q < 2'(MAX_SNOOZE)) begin
                state_q      <= StSnooze;
                snooze_cnt_q <= snooze_cnt_q + 2'd1;
                snz_hm_q     <= snz_target;
              end else begin
                state_q <= StIdle;
              end
            end else if (sec_tick) begin
              ring_timer_q <= ring_timer_q + 8'd1;
              if (ring_timer_q == 8'(RING_TIMEOUT_S - 1)) state_q <= StIdle;
            end
          end
          StSnooze: begin
            if (bus.key_stop) begin
              state_q <= StIdle;
            end else if (snz_hit || alarm_hit) begin
              state_q      <= StRing;
              ring_timer_q <= '0;
            end
          end
`ifdef HOURLY_CHIME_EN
          StChime: begin
            if (alarm_hit) begin
              state_q      <= StRing;
              snooze_cnt_q <= '0;
              ring_timer_q <= '0;
            end else if (bus.music_done || bus.key_stop) begin
              state_q <= StIdle;
            end
          end
`endif
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.play_en       = play_en_q;
  assign bus.ringing       = play_en_q;
  assign bus.snooze_active = snooze_active_q;
  assign bus.snooze_cnt    = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: scoreboard bench for alarm_ctrl with CLK_FREQ=10, RING_TIMEOUT_S=3.
// Define HOURLY_CHIME_EN to also exercise the chime path.
module tb_alarm_ctrl;

  localparam int unsigned CLK_FREQ       = 10;
  localparam int unsigned SNOOZE_MIN     = 5;
  localparam int unsigned RING_TIMEOUT_S = 3;
  localparam int unsigned MAX_SNOOZE     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alarm_ctrl_if bus ();

  alarm_ctrl #(
    .CLK_FREQ      (CLK_FREQ),
    .SNOOZE_MIN    (SNOOZE_MIN),
    .RING_TIMEOUT_S(RING_TIMEOUT_S),
    .MAX_SNOOZE    (MAX_SNOOZE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Expected {play_en, ringing, snooze_active, snooze_cnt}.
  typedef struct {
    string      name;
    logic [4:0] val;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  logic [4:0] obs;

  assign obs = {bus.play_en, bus.ringing, bus.snooze_active, bus.snooze_cnt};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_stop();
    bus.key_stop = 1'b1;
    step(1);
    bus.key_stop = 1'b0;
  endtask

  task automatic pulse_snooze();
    bus.key_snooze = 1'b1;
    step(1);
    bus.key_snooze = 1'b0;
  endtask

  // Drive the second before and the matching second; ringing is visible two edges later.
  task automatic start_ring(input logic [23:0] t_before, input logic [23:0] t_at);
    bus.time_num = t_before;
    step(2);
    bus.time_num = t_at;
    step(2);
  endtask

  task automatic test_reset();
    bus.alarm_on   = 1'b0;
    bus.alarm_hm   = 16'h0730;
    bus.time_num   = 24'h120101;
    bus.key_stop   = 1'b0;
    bus.key_snooze = 1'b0;
`ifdef HOURLY_CHIME_EN
    bus.music_done = 1'b0;
`endif
    rst = 1'b1;
    step(3);
    exp_q.push_back('{"reset_hold", 5'b00000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    rst = 1'b0;
    step(1);
    exp_q.push_back('{"reset_release", 5'b00000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
  endtask

  task automatic test_alarm_basic();
    bus.alarm_on = 1'b1;
    bus.time_num = 24'h072959;
    step(2);
    exp_q.push_back('{"pre_alarm", 5'b00000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    bus.time_num = 24'h073000;
    step(1);
    exp_q.push_back('{"ring_latency1", 5'b00000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    step(1);
    exp_q.push_back('{"ring_latency2", 5'b11000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    pulse_stop();
    step(11);
    exp_q.push_back('{"no_retrigger", 5'b00000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
  endtask

  task automatic test_snooze();
    start_ring(24'h072959, 24'h073000);
    exp_q.push_back('{"snz_ring0", 5'b11000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    bus.time_num = 24'h073010;
    pulse_snooze();
    step(1);
    exp_q.push_back('{"snz_active", 5'b00101});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    bus.time_num = 24'h073400;
    step(3);
    exp_q.push_back('{"snz_early", 5'b00101});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    bus.time_num = 24'h073500;
    step(2);
    exp_q.push_back('{"snz_rering", 5'b11001});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    pulse_stop();
    step(1);
    exp_q.push_back('{"snz_stop_keeps_cnt", 5'b00001});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
  endtask

  task automatic test_wrap();
    bus.alarm_hm = 16'h2358;
    start_ring(24'h235759, 24'h235800);
    exp_q.push_back('{"wrap_ring_cnt_clear", 5'b11000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    pulse_snooze();
    step(1);
    exp_q.push_back('{"wrap_snooze", 5'b00101});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    bus.time_num = 24'h000259;
    step(2);
    exp_q.push_back('{"wrap_wait", 5'b00101});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    bus.time_num = 24'h000300;
    step(2);
    exp_q.push_back('{"wrap_0003_ring", 5'b11001});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    pulse_stop();
    step(1);
  endtask

  task automatic test_max_snooze();
    logic [23:0] rering[3];
    rering[0] = 24'h073500;
    rering[1] = 24'h074000;
    rering[2] = 24'h074500;
    bus.alarm_hm = 16'h0730;
    start_ring(24'h072959, 24'h073000);
    exp_q.push_back('{"max_ring0", 5'b11000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    for (int i = 1; i <= 3; i++) begin
      pulse_snooze();
      step(1);
      exp_q.push_back('{$sformatf("max_snooze%0d", i), {3'b001, 2'(i)}});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
      bus.time_num = rering[i-1];
      step(2);
      exp_q.push_back('{$sformatf("max_rering%0d", i), {3'b110, 2'(i)}});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    end
    pulse_snooze();
    step(1);
    exp_q.push_back('{"max_fourth_is_stop", 5'b00011});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
  endtask

  task automatic test_timeout();
    int n;
    int hi;
    n  = 0;
    hi = 0;
    bus.alarm_hm = 16'h0915;
    bus.time_num = 24'h091459;
    step(2);
    bus.time_num = 24'h091500;
    while (bus.play_en !== 1'b1 && n < 5) begin step(1); n++; end
    while (bus.play_en === 1'b1 && hi < 50) begin step(1); hi++; end
    // Third tick lands 21..30 cycles after entry depending on prescaler phase.
    checks++;
    if (hi < 21 || hi > 30) begin
      errors++;
      $display("FAIL timeout_len got %0d cycles want 21..30", hi);
    end
    exp_q.push_back('{"timeout_idle", 5'b00000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    step(5);
    exp_q.push_back('{"timeout_no_retrigger", 5'b00000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
  endtask

  task automatic test_stop_and_snooze();
    start_ring(24'h091459, 24'h091500);
    pulse_snooze();
    step(1);
    exp_q.push_back('{"both_pre_snooze", 5'b00101});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    bus.time_num = 24'h092000;
    step(2);
    exp_q.push_back('{"both_rering", 5'b11001});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    bus.key_stop   = 1'b1;
    bus.key_snooze = 1'b1;
    step(1);
    bus.key_stop   = 1'b0;
    bus.key_snooze = 1'b0;
    step(1);
    exp_q.push_back('{"both_stop_wins", 5'b00001});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
  endtask

  task automatic test_alarm_off();
    start_ring(24'h091459, 24'h091500);
    pulse_snooze();
    step(1);
    exp_q.push_back('{"off_pre_snooze", 5'b00101});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    bus.alarm_on = 1'b0;
    step(2);
    exp_q.push_back('{"off_idle_cnt_clear", 5'b00000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    start_ring(24'h091459, 24'h091500);
    exp_q.push_back('{"off_no_ring", 5'b00000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    bus.time_num = 24'h091501;
    step(1);
    bus.alarm_on = 1'b1;
    step(1);
  endtask

  task automatic test_rst_mid_ring();
    start_ring(24'h091459, 24'h091500);
    exp_q.push_back('{"rst_pre_ring", 5'b11000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    rst = 1'b1;
    bus.time_num = 24'h091501;
    step(1);
    exp_q.push_back('{"rst_mid_ring", 5'b00000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    rst = 1'b0;
    step(1);
  endtask

`ifdef HOURLY_CHIME_EN
  task automatic test_chime();
    start_ring(24'h075959, 24'h080000);
    exp_q.push_back('{"chime_on", 5'b11000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    step(4);
    exp_q.push_back('{"chime_hold", 5'b11000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    bus.music_done = 1'b1;
    step(1);
    bus.music_done = 1'b0;
    step(1);
    exp_q.push_back('{"chime_done", 5'b00000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    bus.alarm_hm = 16'h0900;
    start_ring(24'h085959, 24'h090000);
    // Alarm at the hour must be RING: music_done has no effect there.
    bus.music_done = 1'b1;
    step(1);
    bus.music_done = 1'b0;
    step(1);
    exp_q.push_back('{"hour_alarm_is_ring", 5'b11000});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.val); end
    pulse_stop();
    step(1);
  endtask
`endif

  initial begin
    test_reset();
    test_alarm_basic();
    test_snooze();
    test_wrap();
    test_max_snooze();
    test_timeout();
    test_stop_and_snooze();
    test_alarm_off();
    test_rst_mid_ring();
`ifdef HOURLY_CHIME_EN
    test_chime();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
